// File: rtl/fp8_sched_pkg.sv
// Shared types and constants for the FP8 operation scheduler:
// FSM state encoding, opcodes and the captured-request record.
package fp8_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // E4M3 NaN, returned on an aborted operation
    localparam logic [7:0] FP8_NAN = 8'h7F;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
    } fp8_req_t;

endpackage

// File: rtl/fp8_rr_arb.sv
// Round-robin priority search: first valid requester at or above i_ptr,
// wrapping modulo N_REQ.
module fp8_rr_arb #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PW-1:0]    o_idx,
    output logic             o_any
);

    logic [PW-1:0] w_cand [N_REQ];

    // w_cand[k] is the requester examined k-th, i.e. (ptr + k) mod N_REQ
    for (genvar k = 0; k < N_REQ; k++) begin : g_cand
        logic [PW:0] w_sum;
        assign w_sum    = {1'b0, i_ptr} + (PW+1)'(k);
        assign w_cand[k] = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ))
                                                      : PW'(w_sum);
    end

    // Scan from lowest priority to highest so the last hit wins
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_valid[w_cand[k]]) begin
                o_idx = w_cand[k];
                o_any = 1'b1;
            end
        end
    end

    assign o_grant = o_any ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/fp8_op_sched.sv
// Arbitrates N_REQ requesters onto one FP8 unit, one operation in flight,
// with a WAIT-state timeout that returns NaN and flags rsp_err.
module fp8_op_sched
    import fp8_sched_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 dp_start,
    output logic [7:0]           dp_a,
    output logic [7:0]           dp_b,
    output logic [1:0]           dp_op,
    input  logic                 dp_done,
    input  logic [7:0]           dp_result,
    output logic                 busy
);

    localparam int PW = $clog2(N_REQ);

    sched_state_e     r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_grant;
    logic [7:0]       r_timer;
    fp8_req_t         r_req;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_err;

    logic [N_REQ-1:0] w_arb_grant;
    logic [PW-1:0]    w_arb_idx;
    logic             w_arb_any;
    logic             w_acc;
    logic             w_done;
    logic             w_tmo;
    logic             w_rsp_hs;

    fp8_rr_arb #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    assign w_acc    = (r_state == ST_IDLE) && w_arb_any;
    assign w_done   = (r_state == ST_WAIT) && dp_done;
    // Timer counts completed WAIT cycles; abort when this cycle would make it TIMEOUT.
    // dp_done on that same cycle takes precedence.
    assign w_tmo    = (r_state == ST_WAIT) && !dp_done && (r_timer == 8'(TIMEOUT - 1));
    assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready[r_grant];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        dp_start    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (!rst) req_ready = w_arb_grant;
                if (w_arb_any) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                dp_start    = !rst;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done || w_tmo) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[r_grant] = !rst;
                if (w_rsp_hs) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_timer    <= '0;
            r_req      <= '0;
            r_rsp_data <= 8'h00;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_grant  <= w_arb_idx;
                r_req.a  <= req_a[8*w_arb_idx +: 8];
                r_req.b  <= req_b[8*w_arb_idx +: 8];
                r_req.op <= req_op[2*w_arb_idx +: 2];
            end
            if (r_state == ST_ISSUE)     r_timer <= '0;
            else if (r_state == ST_WAIT) r_timer <= r_timer + 8'd1;
            if (w_done) begin
                r_rsp_data <= dp_result;
                r_rsp_err  <= 1'b0;
            end else if (w_tmo) begin
                r_rsp_data <= FP8_NAN;
                r_rsp_err  <= 1'b1;
            end
            if (w_rsp_hs) r_ptr <= (r_grant == PW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    assign dp_a     = r_req.a;
    assign dp_b     = r_req.b;
    assign dp_op    = r_req.op;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule

// File: doc/fp8_op_sched.md
FP8_OP_SCHED -- requirements
Module: fp8_op_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, meaning the number of requesters sharing the FP8 datapath (range 2..4).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the WAIT cycles allowed before an operation is aborted (range 2..255).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  per-requester accept; at most one bit high
req_a  in  8*N_REQ  FP8 operand A, requester i at bits [8i+7:8i]
req_b  in  8*N_REQ  FP8 operand B, same packing
req_op  in  2*N_REQ  opcode (00 add, 01 sub, 10 mul, 11 reserved/pass-A)
rsp_valid  out  N_REQ  result valid, only the granted requester's bit
rsp_ready  in  N_REQ  per-requester result accept
rsp_data  out  8  FP8 result
rsp_err  out  1  result is a timeout abort
dp_start  out  1  one-cycle start pulse to the FP8 unit
dp_a, dp_b  out  8 each  operands to the FP8 unit
dp_op  out  2  opcode to the FP8 unit
dp_done  in  1  FP8 unit completion pulse
dp_result  in  8  FP8 unit result, valid with dp_done
busy  out  1  high in every state except IDLE

Function
REQ-005 The block SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-006 In IDLE, req_ready SHALL assert combinationally for the round-robin winner only: the first i with req_valid[i]=1, searching from pointer ptr upward modulo N_REQ.
REQ-007 On req_valid&req_ready, the block SHALL capture operands, opcode and grant index, and go to ISSUE next cycle.
REQ-008 In ISSUE, dp_start SHALL be 1 for exactly one cycle, then the FSM goes to WAIT with the timer cleared to 0.
REQ-009 dp_a, dp_b and dp_op SHALL come from the captured registers and stay stable from ISSUE until leaving WAIT.
REQ-010 In WAIT, dp_done=1 SHALL latch dp_result into rsp_data with rsp_err=0 and go to RESP.
REQ-011 In WAIT without dp_done, the timer SHALL increment each cycle.
REQ-012 When the timer reaches TIMEOUT without dp_done, the block SHALL set rsp_data=8'h7F (E4M3 NaN) and rsp_err=1, and go to RESP.
REQ-013 dp_done arriving on the same cycle the timeout is reached SHALL win: the result is delivered, rsp_err=0.
REQ-014 dp_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-015 In RESP, rsp_valid[grant] SHALL stay high, and rsp_data/rsp_err stable, until rsp_ready[grant]=1; rsp_ready on other bits SHALL be ignored.
REQ-016 On the response handshake, ptr SHALL become (grant+1) mod N_REQ and the FSM SHALL return to IDLE; no new grant in that cycle.
REQ-017 Minimum latency SHALL be: accept at cycle 0, dp_start at cycle 1, rsp_valid at cycle 3 when dp_done arrives at cycle 2.
REQ-018 A requester dropping req_valid before being granted SHALL simply lose arbitration; no state SHALL change.
REQ-019 Only one operation SHALL be in flight; req_ready SHALL be 0 outside IDLE.

Reset
REQ-020 Reset SHALL set: state=IDLE, ptr=0, timer=0, req_ready=0, rsp_valid=0, rsp_data=8'h00, rsp_err=0, dp_start=0, dp_a=dp_b=8'h00, dp_op=2'b00, busy=0.
REQ-021 Reset in any state SHALL discard the in-flight operation without a response; a late dp_done after reset SHALL be ignored.

Structure
REQ-022 Package fp8_sched_pkg SHALL hold the state enum, opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_PASS) and FP8_NAN=8'h7F.
REQ-023 The round-robin priority search SHALL be a sub-module fp8_rr_arb (inputs: valid vector, ptr; outputs: one-hot grant, grant index, any).

Verification
REQ-024 Single requester: req0 mul 8'h3C x 8'h40, bench dp_done after 1 cycle with 8'h44 -> dp_start at cycle 1, rsp_valid[0] at cycle 3, rsp_data=8'h44, rsp_err=0.
REQ-025 Contention: req0 and req1 both valid continuously for four operations -> grants in order 0,1,0,1; req_ready is never multi-hot.
REQ-026 Timeout: dp_done never asserted, TIMEOUT=15 -> rsp_data=8'h7F, rsp_err=1 after 15 WAIT cycles; the next request proceeds normally.
REQ-027 Backpressure: rsp_ready[1] held low 5 cycles -> rsp_valid[1] and rsp_data stay stable; rsp_ready[0]=1 has no effect; busy stays 1.
REQ-028 Reset in WAIT followed by dp_done on the next cycle -> no rsp_valid, state IDLE, ptr=0.
REQ-029 dp_done on the same cycle as timeout expiry with 8'h38 -> rsp_data=8'h38, rsp_err=0.
